// File: rtl/ad9361_cmos_tx_if.sv
// rtl/ad9361_cmos_tx_if.sv - AD9361 2T CMOS TX sample source: pair FIFO, ENABLE/TXNRX pulse sequencing
// Every pin-facing output is a flop loaded from the current state and FIFO head, so pins lag the FSM by one cycle.
module ad9361_cmos_tx_if #(
  parameter int FIFO_DEPTH     = 4,
  parameter int STARTUP_CYCLES = 16,
  parameter int ENABLE_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_i0,
  input  logic [11:0] in_q0,
  input  logic [11:0] in_i1,
  input  logic [11:0] in_q1,
  output logic        frame_q1,
  output logic        frame_q2,
  output logic [11:0] data_p0_q1,
  output logic [11:0] data_p0_q2,
  output logic [11:0] data_p1_q1,
  output logic [11:0] data_p1_q2,
  output logic        enable,
  output logic        txnrx,
  output logic        active,
  output logic        underrun,
  output logic [15:0] underrun_count
);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (STARTUP_CYCLES > ENABLE_CYCLES) ? STARTUP_CYCLES : ENABLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] EN_LAST = CW'(ENABLE_CYCLES - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(STARTUP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_EN_ON, S_WAIT, S_RUN, S_DRAIN, S_EN_OFF
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [47:0]   mem_q [FIFO_DEPTH];
  logic [47:0]   dout_q, dout_d;
  logic          frame_q, frame_d;
  logic          enable_q, enable_d;
  logic          txnrx_q, txnrx_d;
  logic          underrun_q, underrun_d;
  logic [15:0]   ucnt_q, ucnt_d;
  logic          empty, full, running, push, pop;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    running = (state_q == S_RUN) || (state_q == S_DRAIN);
    push    = in_valid && !full;
    pop     = running && !empty;

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE:  if (tx_start) state_d = S_SETUP;
      S_SETUP: begin
        state_d = S_EN_ON;
        cnt_d   = '0;
      end
      S_EN_ON: begin
        if (cnt_q == EN_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT: begin
        if (cnt_q == ST_LAST) state_d = S_RUN;
        else                  cnt_d   = cnt_q + CNT_ONE;
      end
      S_RUN:   if (!tx_start) state_d = S_DRAIN;
      // An empty FIFO here means the previous pop was the last pair.
      S_DRAIN: begin
        if (empty) begin
          state_d = S_EN_OFF;
          cnt_d   = '0;
        end
      end
      S_EN_OFF: begin
        if (cnt_q == EN_LAST) state_d = S_IDLE;
        else                  cnt_d   = cnt_q + CNT_ONE;
      end
      default: state_d = S_IDLE;
    endcase

    txnrx_d    = (state_q != S_IDLE);
    enable_d   = (state_q == S_EN_ON) || (state_q == S_EN_OFF);
    frame_d    = (state_q == S_WAIT) || running;
    dout_d     = pop ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    underrun_d = (state_q == S_RUN) && empty;
    ucnt_d     = (underrun_d && (ucnt_q != 16'hFFFF)) ? ucnt_q + 16'd1 : ucnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dout_q     <= '0;
      frame_q    <= 1'b0;
      enable_q   <= 1'b0;
      txnrx_q    <= 1'b0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      dout_q     <= dout_d;
      frame_q    <= frame_d;
      enable_q   <= enable_d;
      txnrx_q    <= txnrx_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_i0, in_q0, in_i1, in_q1};
  end

  assign in_ready       = !full;
  assign active         = running;
  assign frame_q1       = frame_q;
  assign frame_q2       = 1'b0;
  assign data_p0_q1     = dout_q[47:36];
  assign data_p1_q1     = dout_q[35:24];
  assign data_p0_q2     = dout_q[23:12];
  assign data_p1_q2     = dout_q[11:0];
  assign enable         = enable_q;
  assign txnrx          = txnrx_q;
  assign underrun       = underrun_q;
  assign underrun_count = ucnt_q;
endmodule
